// File: rtl/fetch_pkg.sv
// Shared widths, default sizing and encodings for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned DefDepth = 4;
    localparam int unsigned DefPcw   = 8;
    localparam int unsigned InstrW   = 16;

    typedef enum logic [1:0] {
        ClsAlu    = 2'b00,
        ClsMem    = 2'b01,
        ClsBranch = 2'b10,
        ClsMov    = 2'b11
    } instr_class_e;

    typedef enum logic [1:0] {
        StFetch,
        StFull,
        StRedirect
    } fetch_state_e;

    function automatic instr_class_e decode_class(input logic [InstrW-1:0] word);
        return instr_class_e'(word[InstrW-1:InstrW-2]);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instruction} entries with synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = DefDepth,
    parameter int unsigned Width = DefPcw + InstrW
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [Width-1:0]           data_i,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  head_q, tail_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok, pop_ok;

    always_comb begin
        full_o  = (count_q == CntW'(Depth));
        empty_o = (count_q == '0);
        // A push into a full queue is only legal when the head frees its slot this cycle.
        push_ok = push_i && (!full_o || pop_i);
        pop_ok  = pop_i && !empty_o;
        data_o  = mem_q[head_q];
        count_o = count_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) tail_q <= tail_q + PtrW'(1);
            if (pop_ok)  head_q <= head_q + PtrW'(1);
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[tail_q] <= data_i;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one-cycle-latency memory requests feeding a prefetch queue,
// with jump redirect that flushes queued and in-flight instructions.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned PCW   = DefPcw
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PCW-1:0]    imem_addr,
    output logic              imem_en,
    input  logic [InstrW-1:0] imem_data,
    input  logic              jump,
    input  logic [PCW-1:0]    jump_target,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [InstrW-1:0] instr,
    output logic [PCW-1:0]    instr_pc,
    output logic [1:0]        instr_class
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned EntW = PCW + InstrW;

    fetch_state_e    state_q, state_d;
    logic [PCW-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PCW-1:0]  inflight_pc_q;
    logic            inflight_q;
    logic            issue, push, pop;
    logic [CntW-1:0] count;
    logic            full, empty;
    logic [EntW-1:0] head;
    logic [CntW:0]   occ_now, occ_next;

    fetch_fifo #(
        .Depth (DEPTH),
        .Width (EntW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (jump),
        .data_i  ({inflight_pc_q, imem_data}),
        .data_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        instr_valid = !empty && (state_q != StRedirect);
        instr       = head[InstrW-1:0];
        instr_pc    = head[EntW-1:InstrW];
        instr_class = decode_class(instr);
        pop         = instr_valid && instr_ready;
        push        = inflight_q && !jump;

        // Occupancy counts the in-flight request so the queue can always absorb its response.
        occ_now  = {1'b0, count} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
        issue    = (state_q == StFetch) && !jump && !reset && !full &&
                   (occ_now < (CntW + 1)'(DEPTH));
        occ_next = occ_now + (CntW + 1)'(issue);

        imem_en   = issue;
        imem_addr = fetch_pc_q;

        state_d    = state_q;
        fetch_pc_d = issue ? fetch_pc_q + PCW'(1) : fetch_pc_q;
        if (jump) begin
            state_d    = StRedirect;
            fetch_pc_d = jump_target;
        end else begin
            case (state_q)
                StFetch:    if (occ_next == (CntW + 1)'(DEPTH)) state_d = StFull;
                StFull:     if (pop) state_d = StFetch;
                StRedirect: state_d = StFetch;
                default:    state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StFetch;
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stream table plus redirect/full/reset sequences.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  imem_addr;
    logic        imem_en;
    logic [15:0] imem_data = 16'h0000;
    logic        jump = 1'b0;
    logic [7:0]  jump_target = 8'h00;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic [1:0]  instr_class;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       valid;
        logic [7:0] pc;
        logic       en;
        logic [7:0] addr;
    } vec_t;

    vec_t tbl[8];

    instr_fetch_unit #(
        .DEPTH (4),
        .PCW   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_en     (imem_en),
        .imem_data   (imem_data),
        .jump        (jump),
        .jump_target (jump_target),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_class (instr_class)
    );

    always #5 clk = ~clk;

    // Memory model: word[a] = 16'hA000 + a, returned one cycle after the request.
    always @(posedge clk) begin
        if (imem_en) imem_data <= 16'hA000 + {8'h00, imem_addr};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs change just after the edge, checks happen mid-cycle.
    task automatic apply(input logic r, input logic j, input logic [7:0] t, input logic rs);
        @(posedge clk);
        #1;
        instr_ready = r;
        jump        = j;
        jump_target = t;
        reset       = rs;
        #2;
    endtask

    task automatic expect_head(input string name, input logic [7:0] pc);
        check({name, "_valid"}, 32'(instr_valid), 32'd1);
        check({name, "_pc"}, 32'(instr_pc), 32'(pc));
        check({name, "_instr"}, 32'(instr), 32'(16'hA000 + {8'h00, pc}));
    endtask

    task automatic do_reset();
        apply(1'b0, 1'b0, 8'h00, 1'b1);
        apply(1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_en", 32'(imem_en), 32'd0);
        check("rst_count", 32'(dut.count), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(StFetch));
        check("rst_addr", 32'(imem_addr), 32'd0);
    endtask

    initial begin
        tbl[0] = '{valid: 1'b0, pc: 8'h00, en: 1'b1, addr: 8'h00};
        tbl[1] = '{valid: 1'b0, pc: 8'h00, en: 1'b1, addr: 8'h01};
        tbl[2] = '{valid: 1'b1, pc: 8'h00, en: 1'b1, addr: 8'h02};
        tbl[3] = '{valid: 1'b1, pc: 8'h01, en: 1'b1, addr: 8'h03};
        tbl[4] = '{valid: 1'b1, pc: 8'h02, en: 1'b1, addr: 8'h04};
        tbl[5] = '{valid: 1'b1, pc: 8'h03, en: 1'b1, addr: 8'h05};
        tbl[6] = '{valid: 1'b1, pc: 8'h04, en: 1'b1, addr: 8'h06};
        tbl[7] = '{valid: 1'b1, pc: 8'h05, en: 1'b1, addr: 8'h07};

        // Back-to-back stream after reset release.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            apply(1'b1, 1'b0, 8'h00, 1'b0);
            check($sformatf("strm%0d_valid", k), 32'(instr_valid), 32'(tbl[k].valid));
            check($sformatf("strm%0d_en", k), 32'(imem_en), 32'(tbl[k].en));
            check($sformatf("strm%0d_addr", k), 32'(imem_addr), 32'(tbl[k].addr));
            if (tbl[k].valid) begin
                expect_head($sformatf("strm%0d", k), tbl[k].pc);
                check($sformatf("strm%0d_class", k), 32'(instr_class), 32'(ClsBranch));
            end
        end

        // Stalled consumer fills the queue, then drains without a gap.
        do_reset();
        for (int k = 0; k < 10; k++) apply(1'b0, 1'b0, 8'h00, 1'b0);
        check("full_count", 32'(dut.count), 32'd4);
        check("full_state", 32'(dut.state_q), 32'(StFull));
        check("full_en", 32'(imem_en), 32'd0);
        expect_head("full_head", 8'h00);
        for (int k = 0; k < 6; k++) begin
            apply(1'b1, 1'b0, 8'h00, 1'b0);
            expect_head($sformatf("drain%0d", k), 8'(k));
        end

        // Jump while a request is in flight.
        do_reset();
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("jinf_en0", 32'(imem_en), 32'd1);
        apply(1'b1, 1'b1, 8'h40, 1'b0);
        check("jinf_en_jump", 32'(imem_en), 32'd0);
        check("jinf_valid_jump", 32'(instr_valid), 32'd0);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("jinf_state_redir", 32'(dut.state_q), 32'(StRedirect));
        check("jinf_valid_redir", 32'(instr_valid), 32'd0);
        check("jinf_en_redir", 32'(imem_en), 32'd0);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("jinf_state_fetch", 32'(dut.state_q), 32'(StFetch));
        check("jinf_addr", 32'(imem_addr), 32'h40);
        check("jinf_valid_f1", 32'(instr_valid), 32'd0);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("jinf_valid_f2", 32'(instr_valid), 32'd0);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        expect_head("jinf_first", 8'h40);

        // Jump coincident with a pop and a push.
        do_reset();
        for (int k = 0; k < 5; k++) apply(1'b1, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b1, 8'h10, 1'b0);
        expect_head("jpp_popping", 8'h03);
        check("jpp_inflight", 32'(dut.inflight_q), 32'd1);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("jpp_count", 32'(dut.count), 32'd0);
        check("jpp_valid", 32'(instr_valid), 32'd0);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("jpp_addr", 32'(imem_addr), 32'h10);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        expect_head("jpp_first", 8'h10);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        expect_head("jpp_second", 8'h11);

        // PC wraps from FF to 00.
        apply(1'b1, 1'b1, 8'hFE, 1'b0);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("wrap_addr_fe", 32'(imem_addr), 32'hFE);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("wrap_addr_ff", 32'(imem_addr), 32'hFF);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("wrap_addr_00", 32'(imem_addr), 32'h00);
        expect_head("wrap0", 8'hFE);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        expect_head("wrap1", 8'hFF);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        expect_head("wrap2", 8'h00);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        expect_head("wrap3", 8'h01);

        // Reset mid-stream with three entries queued.
        do_reset();
        for (int k = 0; k < 5; k++) apply(1'b0, 1'b0, 8'h00, 1'b0);
        check("mrst_count", 32'(dut.count), 32'd3);
        expect_head("mrst_head", 8'h00);
        reset = 1'b1;
        #1;
        check("mrst_valid", 32'(instr_valid), 32'd0);
        check("mrst_en", 32'(imem_en), 32'd0);
        apply(1'b1, 1'b0, 8'h00, 1'b1);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("mrst_addr", 32'(imem_addr), 32'h00);
        check("mrst_en_rel", 32'(imem_en), 32'd1);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("mrst_valid_r1", 32'(instr_valid), 32'd0);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        expect_head("mrst_first", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-002 SHALL have parameter PCW, default 8, program-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  PCW  instruction-memory read address.
REQ-006 SHALL have port imem_en  output  1  read request; data is returned exactly 1 cycle later.
REQ-007 SHALL have port imem_data  input  16  instruction word for the previous cycle's request.
REQ-008 SHALL have port jump  input  1  redirect strobe from the control stage.
REQ-009 SHALL have port jump_target  input  PCW  redirect address.
REQ-010 SHALL have port instr_ready  input  1  control stage accepts the head instruction.
REQ-011 SHALL have port instr_valid  output  1  queue head is valid.
REQ-012 SHALL have port instr  output  16  head instruction word.
REQ-013 SHALL have port instr_pc  output  PCW  address of the head instruction.
REQ-014 SHALL have port instr_class  output  2  head instr[15:14]: 00 ALU, 01 load/store, 10 branch, 11 MOV.

Function
REQ-015 SHALL fire a pop only when instr_valid && instr_ready in the same cycle, and SHALL advance the head on that edge.
REQ-016 SHALL drive instr, instr_pc and instr_class combinationally from the queue head, and SHALL hold them stable while instr_valid && !instr_ready.
REQ-017 SHALL assert imem_en iff state==FETCH && !jump && (count + inflight - pop) < DEPTH, with imem_addr = fetch_pc.
REQ-018 SHALL increment fetch_pc modulo 2^PCW (255 -> 0) on each issued request.
REQ-019 SHALL set inflight on an issued request and clear it on the next edge, when imem_data is pushed with its request PC.
REQ-020 SHALL accept a push and a pop in the same cycle, leaving count unchanged.
REQ-021 SHALL implement a state machine with states FETCH, FULL and REDIRECT.
REQ-022 SHALL move FETCH->FULL when the queue plus the inflight request reaches DEPTH, and SHALL move FULL->FETCH on the first pop.
REQ-023 SHALL, on jump from any state, flush the queue (count=0), discard any inflight response, load fetch_pc=jump_target and enter REDIRECT; jump SHALL win over a simultaneous push or pop.
REQ-024 SHALL hold instr_valid=0 and imem_en=0 in REDIRECT for exactly one cycle, then enter FETCH.
REQ-025 SHALL take 2 cycles from the first FETCH cycle (request) to instr_valid (push edge, then head visible).
REQ-026 SHALL sustain 1 instruction/cycle when instr_ready is held high.
REQ-027 SHALL never push into a full queue or pop an empty one.

Reset
REQ-028 SHALL, while reset is high, force fetch_pc=0, count=0, head/tail=0, inflight=0 and state=FETCH, and drive instr_valid=0 and imem_en=0.
REQ-029 SHALL, on reset mid-operation, drop the queue contents and any inflight response; the first request after release SHALL be address 0.

Structure
REQ-030 SHALL place DEPTH, PCW, the instruction width (16) and the instr_class encoding in shared package fetch_pkg.
REQ-031 SHALL use one sub-module, fetch_fifo (DEPTH x {PCW+16}), with push, pop, flush, count, full and empty.

Verification
REQ-032 SHALL verify: reset release, memory word[a]=16'hA000+a, ready=1 -> instr_valid first high 2 cycles later with pc 0, 1, 2... back-to-back.
REQ-033 SHALL verify: ready=0 for 10 cycles -> exactly DEPTH=4 entries, state FULL, imem_en=0, head pc 0 held; then ready=1 -> pcs 0..3 then 4 with no gap.
REQ-034 SHALL verify: jump with target 8'h40 while a request is inflight -> no stale instruction delivered, one REDIRECT bubble, next delivered pc=8'h40.
REQ-035 SHALL verify: jump asserted coincident with a pop and a push -> queue empty next cycle and pc sequence restarts at the target.
REQ-036 SHALL verify: start at jump_target 8'hFE -> delivered pcs FE, FF, 00, 01.
REQ-037 SHALL verify: reset asserted mid-stream with 3 entries queued -> instr_valid=0 immediately; after release the first pc delivered is 0.
